// File: rtl/pong_game_ctrl_pkg.sv
// Shared definitions for the Pong match controller: FSM state encodings,
// default match length and the serve-direction encoding (also used by the
// ball module to pick the sign of the serve velocity).
package pong_game_ctrl_pkg;

    localparam int unsigned STATE_W       = 3;
    localparam int unsigned DEF_WIN_SCORE = 7;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic SERVE_LEFT  = 1'b0;
    localparam logic SERVE_RIGHT = 1'b1;

    // Width of a counter that must reach the larger of two terminal counts.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Controller <-> game-world signal bundle.
//   master : the match controller (consumes ticks/buttons/misses, drives
//            ball gating, scores and status)
//   slave  : the surrounding datapath (tick generator, collision logic,
//            ball and score display)
interface pong_game_ctrl_if #(
    parameter int unsigned SCORE_W = 4
);
    import pong_game_ctrl_pkg::*;

    logic               refr_tick;
    logic               start_btn;
    logic               miss_l;
    logic               miss_r;
    logic               ball_run;
    logic               ball_hold;
    logic               serve_dir;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
    logic               game_over;
    logic               winner;
    logic [STATE_W-1:0] state;

    modport master (
        input  refr_tick, start_btn, miss_l, miss_r,
        output ball_run, ball_hold, serve_dir, score_l, score_r,
               game_over, winner, state
    );

    modport slave (
        output refr_tick, start_btn, miss_l, miss_r,
        input  ball_run, ball_hold, serve_dir, score_l, score_r,
               game_over, winner, state
    );

endinterface

// File: rtl/pong_game_ctrl_frame_timer.sv
// Frame-tick counter with synchronous clear and terminal-count detect.
//   clk, rstn : clock, async active-low reset
//   clr       : clear counter (takes priority over counting)
//   en        : count enable (one frame tick)
//   term      : terminal count (>= 1)
//   done_c    : combinational pulse on the tick that reaches term
module pong_game_ctrl_frame_timer #(
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt;

    // Tick counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // The tick that would bring the count to term is the term-th tick.
    assign done_c = en & (cnt == (term - CNT_W'(1)));

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match-sequencing controller: gates the ball frame tick, holds the
// ball for serves, counts points from miss pulses and declares a winner.
//   clk, rstn : clock, async active-low reset
//   bus       : pong_game_ctrl_if.master (ticks, start, misses in;
//               ball_run/ball_hold/serve_dir/scores/game_over/winner/state out)
// ball_run is the only combinational output; all others are registered.
module pong_game_ctrl
    import pong_game_ctrl_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = DEF_WIN_SCORE,
    parameter int unsigned SERVE_TICKS = 60,
    parameter int unsigned POINT_TICKS = 90,
    parameter int unsigned SCORE_W     = 4
) (
    input  logic             clk,
    input  logic             rstn,
    pong_game_ctrl_if.master bus
);

    localparam int unsigned CNT_W = cnt_width(SERVE_TICKS, POINT_TICKS);
    localparam logic [CNT_W-1:0]   SERVE_TERM = CNT_W'(SERVE_TICKS);
    localparam logic [CNT_W-1:0]   POINT_TERM = CNT_W'(POINT_TICKS);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    state_e             state_q,     state_d;
    logic [SCORE_W-1:0] score_l_q,   score_l_d;
    logic [SCORE_W-1:0] score_r_q,   score_r_d;
    logic               serve_dir_q, serve_dir_d;
    logic               game_over_q, game_over_d;
    logic               winner_q,    winner_d;
    logic               ball_hold_q, ball_hold_d;
    logic               start_q;

    logic               start_edge_c;
    logic               timer_en_c;
    logic               timer_clr_c;
    logic               timer_done_c;
    logic [CNT_W-1:0]   timer_term_c;

    assign start_edge_c = bus.start_btn & ~start_q;
    assign timer_en_c   = bus.refr_tick & ((state_q == ST_SERVE) | (state_q == ST_POINT));
    assign timer_term_c = (state_q == ST_POINT) ? POINT_TERM : SERVE_TERM;
    // Every state entry restarts the frame count.
    assign timer_clr_c  = (state_d != state_q);

    pong_game_ctrl_frame_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (timer_clr_c),
        .en     (timer_en_c),
        .term   (timer_term_c),
        .done_c (timer_done_c)
    );

    // State and registered-output storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            score_l_q   <= '0;
            score_r_q   <= '0;
            serve_dir_q <= SERVE_RIGHT;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            ball_hold_q <= 1'b1;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            serve_dir_q <= serve_dir_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            ball_hold_q <= ball_hold_d;
            start_q     <= bus.start_btn;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        serve_dir_d = serve_dir_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge_c) begin
                    state_d     = ST_SERVE;
                    score_l_d   = '0;
                    score_r_d   = '0;
                    serve_dir_d = SERVE_RIGHT;
                    game_over_d = 1'b0;
                end
            end
            ST_SERVE: begin
                if (timer_done_c) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (bus.miss_l && bus.miss_r) begin
                    // Simultaneous misses: replay the serve, no point.
                    state_d = ST_SERVE;
                end else if (bus.miss_l) begin
                    state_d     = ST_POINT;
                    score_r_d   = score_r_q + SCORE_W'(1);
                    serve_dir_d = SERVE_LEFT;
                end else if (bus.miss_r) begin
                    state_d     = ST_POINT;
                    score_l_d   = score_l_q + SCORE_W'(1);
                    serve_dir_d = SERVE_RIGHT;
                end
            end
            ST_POINT: begin
                if (timer_done_c) begin
                    if ((score_l_q == WIN) || (score_r_q == WIN)) begin
                        state_d     = ST_OVER;
                        game_over_d = 1'b1;
                        winner_d    = (score_r_q == WIN);
                    end else begin
                        state_d = ST_SERVE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ball_hold_d = (state_d != ST_PLAY) && (state_d != ST_POINT);
    end

    assign bus.ball_run  = bus.refr_tick & (state_q == ST_PLAY);
    assign bus.ball_hold = ball_hold_q;
    assign bus.serve_dir = serve_dir_q;
    assign bus.score_l   = score_l_q;
    assign bus.score_r   = score_r_q;
    assign bus.game_over = game_over_q;
    assign bus.winner    = winner_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed match scenarios plus a random phase,
// all checked every cycle against a game-level reference model.
module tb_pong_game_ctrl;

    localparam int unsigned WIN   = 2;
    localparam int unsigned SERVE = 3;
    localparam int unsigned POINT = 2;
    localparam int unsigned SW    = 4;

    logic clk;
    logic rstn;

    pong_game_ctrl_if #(.SCORE_W(SW)) bus ();

    pong_game_ctrl #(
        .WIN_SCORE   (WIN),
        .SERVE_TICKS (SERVE),
        .POINT_TICKS (POINT),
        .SCORE_W     (SW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Reference model: game phase (numbered as on screen), frames left in
    // the current wait, scores, serve side, match status.
    int m_mode;
    int m_left;
    int m_sl;
    int m_sr;
    int m_dir;
    int m_over;
    int m_win;
    int m_prev_start;
    int cur_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_sl = 0; m_sr = 0;
        m_dir = 1; m_over = 0; m_win = 0; m_prev_start = 0;
    endtask

    task automatic model_step(input int t, input int s, input int l, input int r);
        int edge_seen;
        edge_seen = (s != 0) && (m_prev_start == 0);
        m_prev_start = s;
        case (m_mode)
            0, 4: if (edge_seen) begin
                m_mode = 1; m_left = SERVE; m_sl = 0; m_sr = 0; m_dir = 1; m_over = 0;
            end
            1: if (t != 0) begin
                m_left = m_left - 1;
                if (m_left == 0) m_mode = 2;
            end
            2: begin
                if (l != 0 && r != 0) begin
                    m_mode = 1; m_left = SERVE;
                end else if (l != 0) begin
                    m_sr = m_sr + 1; m_dir = 0; m_mode = 3; m_left = POINT;
                end else if (r != 0) begin
                    m_sl = m_sl + 1; m_dir = 1; m_mode = 3; m_left = POINT;
                end
            end
            3: if (t != 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_sl == WIN || m_sr == WIN) begin
                        m_mode = 4; m_over = 1; m_win = (m_sr == WIN) ? 1 : 0;
                    end else begin
                        m_mode = 1; m_left = SERVE;
                    end
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic check_all();
        chk("state",     int'(bus.state),     m_mode);
        chk("score_l",   int'(bus.score_l),   m_sl);
        chk("score_r",   int'(bus.score_r),   m_sr);
        chk("serve_dir", int'(bus.serve_dir), m_dir);
        chk("ball_hold", int'(bus.ball_hold), (m_mode == 2 || m_mode == 3) ? 0 : 1);
        chk("ball_run",  int'(bus.ball_run),  (cur_t != 0 && m_mode == 2) ? 1 : 0);
        chk("game_over", int'(bus.game_over), m_over);
        chk("winner",    int'(bus.winner),    m_win);
    endtask

    // Drive one cycle's inputs at the falling edge and compare.
    task automatic apply(input int t, input int s, input int l, input int r);
        @(negedge clk);
        bus.refr_tick = 1'(t);
        bus.start_btn = 1'(s);
        bus.miss_l    = 1'(l);
        bus.miss_r    = 1'(r);
        cur_t = t;
        #1;
        check_all();
    endtask

    // Let the rising edge happen and advance the model.
    task automatic commit();
        @(posedge clk);
        if (!rstn) model_reset();
        else model_step(int'(bus.refr_tick), int'(bus.start_btn),
                        int'(bus.miss_l), int'(bus.miss_r));
        #1;
    endtask

    task automatic cyc(input int t, input int s, input int l, input int r);
        apply(t, s, l, r);
        commit();
    endtask

    task automatic start_press();
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 0, 0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cur_t = 0;
        rstn  = 1'b0;
        bus.refr_tick = 1'b0;
        bus.start_btn = 1'b0;
        bus.miss_l    = 1'b0;
        bus.miss_r    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Idle for 10 frames: nothing moves.
        ticks(10);
        chk("idle_state", int'(bus.state), 0);
        chk("idle_hold",  int'(bus.ball_hold), 1);
        chk("idle_score", int'(bus.score_l) + int'(bus.score_r), 0);

        // Serve timing: exactly SERVE ticks in SERVE.
        start_press();
        chk("serve_enter", int'(bus.state), 1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("serve_after2", int'(bus.state), 1);
        apply(1, 0, 0, 0);
        chk("serve_tick3_no_run", int'(bus.ball_run), 0);
        commit();
        chk("play_enter", int'(bus.state), 2);
        apply(1, 0, 0, 0);
        chk("first_run", int'(bus.ball_run), 1);
        commit();

        // Left misses: right scores, serve goes left.
        cyc(0, 0, 1, 0);
        chk("pt_state", int'(bus.state), 3);
        chk("pt_score_r", int'(bus.score_r), 1);
        chk("pt_dir", int'(bus.serve_dir), 0);
        ticks(POINT);
        chk("pt_to_serve", int'(bus.state), 1);

        // Let: both miss together.
        ticks(SERVE);
        cyc(0, 0, 1, 1);
        chk("let_state", int'(bus.state), 1);
        chk("let_score_r", int'(bus.score_r), 1);
        chk("let_dir", int'(bus.serve_dir), 0);

        // Two right misses win the match for the left player.
        ticks(SERVE);
        cyc(1, 0, 0, 1);
        ticks(POINT);
        ticks(SERVE);
        cyc(0, 0, 0, 1);
        ticks(POINT);
        chk("over_state", int'(bus.state), 4);
        chk("over_flag", int'(bus.game_over), 1);
        chk("over_winner", int'(bus.winner), 0);
        chk("over_score_l", int'(bus.score_l), 2);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 1);
        chk("over_ignores", int'(bus.state), 4);
        start_press();
        chk("restart_state", int'(bus.state), 1);
        chk("restart_over", int'(bus.game_over), 0);
        chk("restart_score", int'(bus.score_l) + int'(bus.score_r), 0);

        // Reach POINT with 1/1, then async reset between clock edges.
        ticks(SERVE);
        cyc(0, 0, 1, 0);
        ticks(POINT);
        ticks(SERVE);
        cyc(0, 0, 0, 1);
        chk("pre_rst_state", int'(bus.state), 3);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_state", int'(bus.state), 0);
        chk("arst_score_l", int'(bus.score_l), 0);
        chk("arst_score_r", int'(bus.score_r), 0);
        chk("arst_hold", int'(bus.ball_hold), 1);
        chk("arst_dir", int'(bus.serve_dir), 1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Random play.
        begin
            int s;
            s = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(14) == 0) s = 1 - s;
                cyc(($urandom_range(1) == 0) ? 1 : 0, s,
                    ($urandom_range(7) == 0) ? 1 : 0,
                    ($urandom_range(7) == 0) ? 1 : 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Match-sequencing controller for the Pong datapath. It decides when the ball module may move, when it is held at centre, and which way it serves. It counts points from miss pulses produced by the collision logic and declares a winner. It sits between the frame-tick generator and the ball/score-display modules, and gates the ball's `refr_tick`.

## Interface

Parameters:
- `WIN_SCORE`, 7: points needed to win a match (1..15).
- `SERVE_TICKS`, 60: frame ticks the ball is held at centre before each serve (≥1).
- `POINT_TICKS`, 90: frame ticks the ball is frozen after a point (≥1).
- `SCORE_W`, 4: score counter width; must hold `WIN_SCORE`.

Ports:
- `clk` in 1: system clock; the only clock.
- `rstn` in 1: asynchronous, active-low reset.
- `refr_tick` in 1: one-cycle pulse per video frame.
- `start_btn` in 1: debounced level. Rising edge detected internally.
- `miss_l` in 1: one-cycle pulse; ball passed the left paddle.
- `miss_r` in 1: one-cycle pulse; ball passed the right paddle.
- `ball_run` out 1: gated frame tick for the ball module.
- `ball_hold` out 1: ball forced to centre with velocity loaded from `serve_dir`.
- `serve_dir` out 1: 0 = serve toward left, 1 = toward right.
- `score_l`, `score_r` out `SCORE_W`: player scores.
- `game_over` out 1: match finished.
- `winner` out 1: 0 = left, 1 = right. Valid while `game_over`.
- `state` out 3: current FSM state, for on-screen text.

## Operation

- **States:** `IDLE`(0), `SERVE`(1), `PLAY`(2), `POINT`(3), `OVER`(4).
- **IDLE:** `ball_hold`=1.
  - Start rising edge → `SERVE`. Scores cleared, `serve_dir`=1, frame counter cleared.
- **SERVE:** `ball_hold`=1. Counts `refr_tick`.
  - On the `SERVE_TICKS`-th tick → `PLAY`, counter cleared.
- **PLAY:** `ball_hold`=0, `ball_run` = `refr_tick`.
  - `miss_l` only: `score_r`+1, `serve_dir`=0, → `POINT`.
  - `miss_r` only: `score_l`+1, `serve_dir`=1, → `POINT`.
  - Both in the same cycle: let. No score change, `serve_dir` unchanged, → `SERVE`.
- **POINT:** `ball_hold`=0, `ball_run`=0 (ball frozen where it left). Counts `POINT_TICKS` ticks, then:
  - either score == `WIN_SCORE` → `OVER`. Set `game_over`=1; `winner`=1 if `score_r` == `WIN_SCORE`, else 0.
  - otherwise → `SERVE`.
- **OVER:** `ball_hold`=1, scores held.
  - Start rising edge → `SERVE`. Scores cleared, `game_over`=0, `serve_dir`=1.
- **Ignored inputs:**
  - `miss_l`/`miss_r` outside `PLAY`.
  - Start edges outside `IDLE`/`OVER`.
- **Score arithmetic:** unsigned `SCORE_W`-bit. Cannot exceed `WIN_SCORE` because `POINT` always exits to `OVER` at `WIN_SCORE`, so no wrap is possible.
- **Frame counter:** width is clog2(max(`SERVE_TICKS`,`POINT_TICKS`)+1). It increments only on `refr_tick` and is cleared on every state entry.

## Timing

- **Reset values:** state `IDLE`, scores 0, `serve_dir`=1, `ball_hold`=1, `ball_run`=0, `game_over`=0, `winner`=0, counter 0, start-edge register 0.
- **Reset mid-operation:** all of the above, immediately (asynchronous assert). Deassertion is synchronized externally.
- **Registered outputs:** all outputs except `ball_run`. They change one clk after the causing event.
- **`ball_run`:** combinational `refr_tick & (state==PLAY)`. Zero latency from `refr_tick`.
- **Start edge:** detected from a registered copy of `start_btn`. The FSM leaves `IDLE`/`OVER` in the cycle after the edge cycle.
- **Serve duration:** the `PLAY` transition occurs on the clk after the `SERVE_TICKS`-th `refr_tick` counted in `SERVE`. The first `ball_run` is the next `refr_tick` after that.
- **Miss/tick coincidence:** a miss arriving in the same cycle as `refr_tick` in `PLAY` still scores. `ball_run` pulses that cycle. State is `POINT` next cycle.
- **Score vs. state update:** the score increments in the same clk edge as the `PLAY`→`POINT` transition.

## Structure

- **Shared header `pong_defs.vh`:**
  - state encodings (`ST_IDLE`..`ST_OVER`);
  - default `WIN_SCORE`;
  - the `serve_dir` encoding, also used by the ball module to load velocity sign.
- **Sub-module `frame_timer`:** clear / `refr_tick`-enable / terminal-count compare, parameterized by width. It produces a `done` pulse. Instantiated once; the FSM muxes the terminal value (`SERVE_TICKS` or `POINT_TICKS`) by state.

## Test plan

- **Reset:** reset, then release, then idle 10 frames → `state`=0, scores 0, `ball_hold`=1, `ball_run` never pulses.
- **Serve timing:** start edge with `SERVE_TICKS`=3 → `SERVE` for exactly 3 `refr_tick`s; `PLAY` entered on the clk after the 3rd; first `ball_run` on the 4th tick.
- **Scoring:** in `PLAY`, pulse `miss_l` → next clk `score_r`=1, `serve_dir`=0, `state`=3. After `POINT_TICKS` ticks → `state`=1.
- **Let:** `miss_l` and `miss_r` in the same cycle → scores unchanged, `serve_dir` unchanged, `state`=1.
- **Match end and restart:** `WIN_SCORE`=2, two `miss_r` points → `state`=4, `game_over`=1, `winner`=0, `score_l`=2. Misses and ticks now are ignored. Start edge → scores 0, `game_over`=0, `state`=1.
- **Async reset during `POINT` with scores 1/1** → all outputs at reset values immediately, without waiting for a clk edge.
